// File: rtl/prirv32_mem_arbiter.sv
// prirv32_mem_arbiter
// Shares the single core memory port between the IFU (instruction fetch)
// and the LSU (data access). One bus transaction is outstanding at a time.
// The FSM walks IDLE -> REQ -> WAIT -> IDLE and only IDLE can grant.
// Default build: fixed LSU priority, with a starvation guard that forces
// the IFU to win after STARVE_LIMIT consecutive losses.
// Optional build macro PRIRV32_ARB_RR_EN: round-robin arbitration replaces
// the fixed priority and the starvation guard.
// A fetch that is flushed while in flight still completes on the bus, but
// its response is dropped. LSU transactions are never dropped.
module prirv32_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ifu_req_i,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_gnt_o,
    input  logic                ifu_flush_i,
    output logic                ifu_rvalid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                drop_q, drop_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    // Arbitration result, valid only while IDLE is evaluated
    logic                ifu_win;
    logic                lsu_win;

`ifdef PRIRV32_ARB_RR_EN
    // Round-robin pointer: 0 names the IFU, 1 names the LSU
    logic                rr_q, rr_d;

    // On a tie the requester named by the pointer wins
    always_comb begin
        lsu_win = lsu_req_i & (~ifu_req_i | rr_q);
        ifu_win = ifu_req_i & ~lsu_win;
    end

    // Point at the other requester after every grant
    always_comb begin
        rr_d = rr_q;
        if (ifu_gnt_o) begin
            rr_d = 1'b1;
        end else if (lsu_gnt_o) begin
            rr_d = 1'b0;
        end
    end

    // Round-robin pointer register, IFU first out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]          starve_q, starve_d;

    // LSU has priority unless the IFU has lost STARVE_LIMIT times in a row
    always_comb begin
        lsu_win = lsu_req_i & ~(ifu_req_i & (starve_q == STARVE_MAX));
        ifu_win = ifu_req_i & ~lsu_win;
    end

    // Count consecutive IFU losses; any IFU grant or idle IFU clears it
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (!ifu_req_i || ifu_gnt_o) begin
                starve_d = 4'd0;
            end else if (lsu_gnt_o && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // FSM next state, grants, bus request, response routing and drop flag
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        ifu_gnt_o    = 1'b0;
        lsu_gnt_o    = 1'b0;
        ifu_rvalid_o = 1'b0;
        lsu_rvalid_o = 1'b0;
        mem_req_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Grants are forced low while reset is held so every
                // output reads zero during reset.
                ifu_gnt_o = ifu_win & ~rst_i;
                lsu_gnt_o = lsu_win & ~rst_i;
                if (lsu_gnt_o) begin
                    state_d = ST_REQ;
                    owner_d = OWN_LSU;
                    drop_d  = 1'b0;
                    we_d    = lsu_we_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    be_d    = lsu_be_i;
                end else if (ifu_gnt_o) begin
                    state_d = ST_REQ;
                    owner_d = OWN_IFU;
                    // A redirect in the grant cycle already kills this fetch
                    drop_d  = ifu_flush_i;
                    we_d    = 1'b0;
                    addr_d  = ifu_addr_i;
                    wdata_d = '0;
                    be_d    = '1;
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (owner_q == OWN_IFU && ifu_flush_i) begin
                    drop_d = 1'b1;
                end
                // A response in the same cycle as the bus grant is illegal
                // and deliberately ignored here.
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_q == OWN_IFU && ifu_flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    // A redirect arriving with the data also discards it
                    ifu_rvalid_o = (owner_q == OWN_IFU) & ~drop_q & ~ifu_flush_i;
                    lsu_rvalid_o = (owner_q == OWN_LSU);
                    state_d      = ST_IDLE;
                    owner_d      = OWN_NONE;
                    drop_d       = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // State, owner, drop flag and latched bus command
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

    // Read data passes straight through, zero when not valid for that port
    assign ifu_rdata_o = ifu_rvalid_o ? mem_rdata_i : '0;
    assign lsu_rdata_o = lsu_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_prirv32_mem_arbiter.sv
// Directed bench for prirv32_mem_arbiter: a vector table of complete
// single-cycle-bus transactions followed by hand-written sequences for
// flush, a stalled bus grant and reset in the middle of a transaction.
module tb_prirv32_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_IFU  = 2'd1;
    localparam logic [1:0] W_LSU  = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_req;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_gnt;
    logic              ifu_flush;
    logic              ifu_rvalid;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [BE_W-1:0]   lsu_be;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       ifu_req;
        logic       lsu_req;
        logic       lsu_we;
        logic [1:0] win;
        logic [1:0] win_rr;
    } vec_t;

    vec_t vecs [12];

    prirv32_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .ifu_req_i(ifu_req),
        .ifu_addr_i(ifu_addr),
        .ifu_gnt_o(ifu_gnt),
        .ifu_flush_i(ifu_flush),
        .ifu_rvalid_o(ifu_rvalid),
        .ifu_rdata_o(ifu_rdata),
        .lsu_req_i(lsu_req),
        .lsu_we_i(lsu_we),
        .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata),
        .lsu_be_i(lsu_be),
        .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid),
        .lsu_rdata_o(lsu_rdata),
        .mem_req_o(mem_req),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be),
        .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req    = 1'b0;
        ifu_addr   = '0;
        ifu_flush  = 1'b0;
        lsu_req    = 1'b0;
        lsu_we     = 1'b0;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        lsu_be     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // One table entry: request in IDLE, bus grants next cycle, responds the cycle after
    task automatic run_vec(input int i, input vec_t v);
        logic [1:0]        w;
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] rd;
        logic [BE_W-1:0]   be;
`ifdef PRIRV32_ARB_RR_EN
        w = v.win_rr;
`else
        w = v.win;
`endif
        ia = 32'h8000_0000 + 32'(i * 4);
        la = 32'h8000_1000 + 32'(i * 16);
        wd = 32'hA5A5_0000 | 32'(i);
        rd = 32'h0432_8863 + 32'(i);
        be = 4'(i + 1);

        ifu_req   = v.ifu_req;
        ifu_addr  = ia;
        lsu_req   = v.lsu_req;
        lsu_we    = v.lsu_we;
        lsu_addr  = la;
        lsu_wdata = wd;
        lsu_be    = be;
        #3;
        check($sformatf("v%0d_ifu_gnt", i), 64'(ifu_gnt), 64'(w == W_IFU));
        check($sformatf("v%0d_lsu_gnt", i), 64'(lsu_gnt), 64'(w == W_LSU));
        if (w == W_NONE) begin
            check($sformatf("v%0d_idle_mem_req", i), 64'(mem_req), 64'd0);
            next_cycle();
            return;
        end

        next_cycle();
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        mem_gnt = 1'b1;
        #3;
        check($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'd1);
        check($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'((w == W_IFU) ? ia : la));
        check($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'((w == W_LSU) ? v.lsu_we : 1'b0));
        if (w == W_LSU) begin
            check($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(wd));
            check($sformatf("v%0d_mem_be", i), 64'(mem_be), 64'(be));
        end

        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        #3;
        check($sformatf("v%0d_mem_req_off", i), 64'(mem_req), 64'd0);
        check($sformatf("v%0d_ifu_rvalid", i), 64'(ifu_rvalid), 64'(w == W_IFU));
        check($sformatf("v%0d_lsu_rvalid", i), 64'(lsu_rvalid), 64'(w == W_LSU));
        if (w == W_IFU) begin
            check($sformatf("v%0d_ifu_rdata", i), 64'(ifu_rdata), 64'(rd));
        end else begin
            check($sformatf("v%0d_lsu_rdata", i), 64'(lsu_rdata), 64'(rd));
        end

        next_cycle();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Outputs that must all read zero while reset is held
    task automatic check_all_zero(input string tag);
        check({tag, "_ifu_gnt"}, 64'(ifu_gnt), 64'd0);
        check({tag, "_lsu_gnt"}, 64'(lsu_gnt), 64'd0);
        check({tag, "_ifu_rvalid"}, 64'(ifu_rvalid), 64'd0);
        check({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'd0);
        check({tag, "_ifu_rdata"}, 64'(ifu_rdata), 64'd0);
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation_time_exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        //                ifu   lsu   we    fixed  rr
        vecs[0]  = '{1'b1, 1'b0, 1'b0, W_IFU,  W_IFU};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, W_LSU,  W_LSU};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, W_LSU,  W_IFU};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, W_LSU,  W_LSU};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, W_LSU,  W_IFU};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, W_LSU,  W_LSU};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, W_IFU,  W_IFU};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, W_LSU,  W_LSU};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, W_NONE, W_NONE};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, W_LSU,  W_IFU};
        vecs[10] = '{1'b1, 1'b1, 1'b1, W_LSU,  W_LSU};
        vecs[11] = '{1'b1, 1'b0, 1'b0, W_IFU,  W_IFU};

        // Reset state, with both requesters asking to confirm no grant leaks
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ifu_req = 1'b1;
        lsu_req = 1'b1;
        #3;
        check_all_zero("reset");
        next_cycle();
        clear_inputs();
        rst = 1'b0;

        // Table of complete transactions (includes the fetch at 0x80000000
        // returning 0x04328863, and the four-LSU-then-IFU starvation pattern)
        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush during WAIT, response arrives two cycles after the flush
        ifu_req  = 1'b1;
        ifu_addr = 32'h8000_0100;
        #3;
        check("fl_wait_gnt", 64'(ifu_gnt), 64'd1);
        next_cycle();
        ifu_req = 1'b0;
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt   = 1'b0;
        ifu_flush = 1'b1;
        #3;
        check("fl_wait_rvalid_flushcyc", 64'(ifu_rvalid), 64'd0);
        next_cycle();
        ifu_flush = 1'b0;
        next_cycle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        #3;
        check("fl_wait_rvalid_dropped", 64'(ifu_rvalid), 64'd0);
        check("fl_wait_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        ifu_req    = 1'b1;
        ifu_addr   = 32'h8000_0200;
        #3;
        check("fl_next_gnt", 64'(ifu_gnt), 64'd1);
        check("fl_next_mem_req_idle", 64'(mem_req), 64'd0);
        next_cycle();
        ifu_req = 1'b0;
        mem_gnt = 1'b1;
        #3;
        check("fl_next_mem_addr", 64'(mem_addr), 64'h8000_0200);
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_4444;
        #3;
        check("fl_next_rvalid", 64'(ifu_rvalid), 64'd1);
        check("fl_next_rdata", 64'(ifu_rdata), 64'h3333_4444);
        next_cycle();
        mem_rvalid = 1'b0;

        // Flush in the grant cycle itself also drops the fetch
        ifu_req   = 1'b1;
        ifu_addr  = 32'h8000_0300;
        ifu_flush = 1'b1;
        #3;
        check("fl_idle_gnt", 64'(ifu_gnt), 64'd1);
        next_cycle();
        ifu_req   = 1'b0;
        ifu_flush = 1'b0;
        mem_gnt   = 1'b1;
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        #3;
        check("fl_idle_rvalid_dropped", 64'(ifu_rvalid), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;

        // Flush never touches an LSU transaction
        lsu_req  = 1'b1;
        lsu_addr = 32'h8000_2000;
        #3;
        check("fl_lsu_gnt", 64'(lsu_gnt), 64'd1);
        next_cycle();
        lsu_req   = 1'b0;
        ifu_flush = 1'b1;
        mem_gnt   = 1'b1;
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_6666;
        #3;
        check("fl_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        check("fl_lsu_rdata", 64'(lsu_rdata), 64'h5555_6666);
        check("fl_lsu_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        ifu_flush  = 1'b0;

        // LSU write with the bus grant held off for three cycles
        lsu_req   = 1'b1;
        lsu_we    = 1'b1;
        lsu_addr  = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_be    = 4'b0011;
        #3;
        check("wr_gnt", 64'(lsu_gnt), 64'd1);
        next_cycle();
        lsu_we    = 1'b0;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'h0;
        lsu_be    = 4'b1111;
        ifu_req   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("wr_stall%0d_mem_req", k), 64'(mem_req), 64'd1);
            check($sformatf("wr_stall%0d_mem_we", k), 64'(mem_we), 64'd1);
            check($sformatf("wr_stall%0d_mem_addr", k), 64'(mem_addr), 64'h8000_1000);
            check($sformatf("wr_stall%0d_mem_wdata", k), 64'(mem_wdata), 64'hDEAD_BEEF);
            check($sformatf("wr_stall%0d_mem_be", k), 64'(mem_be), 64'b0011);
            check($sformatf("wr_stall%0d_lsu_gnt", k), 64'(lsu_gnt), 64'd0);
            check($sformatf("wr_stall%0d_ifu_gnt", k), 64'(ifu_gnt), 64'd0);
            next_cycle();
        end
        mem_gnt = 1'b1;
        lsu_req = 1'b0;
        ifu_req = 1'b0;
        #3;
        check("wr_gntcyc_mem_req", 64'(mem_req), 64'd1);
        check("wr_gntcyc_mem_addr", 64'(mem_addr), 64'h8000_1000);
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        #3;
        check("wr_ack_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        check("wr_ack_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        #3;
        check("wr_after_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        next_cycle();

        // Reset asserted in WAIT with a response on the bus
        ifu_req  = 1'b1;
        ifu_addr = 32'h8000_0400;
        #3;
        check("rst_gnt", 64'(ifu_gnt), 64'd1);
        next_cycle();
        ifu_req = 1'b0;
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        #2;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_8888;
        ifu_req    = 1'b1;
        lsu_req    = 1'b1;
        rst        = 1'b1;
        #1;
        check_all_zero("rst_wait");
        next_cycle();
        rst     = 1'b0;
        ifu_req = 1'b0;
        lsu_req = 1'b0;
        #3;
        check("rst_rel_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        check("rst_rel_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        check("rst_rel_mem_req", 64'(mem_req), 64'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        ifu_req    = 1'b1;
        ifu_addr   = 32'h8000_0500;
        #3;
        check("rst_rel_gnt", 64'(ifu_gnt), 64'd1);
        next_cycle();
        ifu_req = 1'b0;
        mem_gnt = 1'b1;
        #3;
        check("rst_rel_mem_addr", 64'(mem_addr), 64'h8000_0500);
        next_cycle();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_AAAA;
        #3;
        check("rst_rel_rvalid", 64'(ifu_rvalid), 64'd1);
        check("rst_rel_rdata", 64'(ifu_rdata), 64'h9999_AAAA);
        next_cycle();
        mem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
